// File: rtl/lsf_theta_scan_ctrl.sv
// Theta-scan controller: buffers incoming hits and issues THETA_BINS theta steps per hit.
// Define LSF_HIT_FIFO_EN for a FIFO_DEPTH-entry hit buffer; otherwise a single-entry register.
module lsf_theta_scan_ctrl #(
    parameter int unsigned THETA_BINS           = 128,
    parameter int unsigned FIFO_DEPTH           = 8,
    parameter int unsigned PIPE_LAT             = 2,
    parameter int unsigned W_R                  = 22,
    parameter int unsigned W_TH                 = 7,
    parameter int unsigned HEG2SFHIT_LOCALX_LEN = 16,
    parameter int unsigned HEG2SFHIT_LOCALY_LEN = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            hit_vld,
    output logic                            hit_rdy,
    input  logic [HEG2SFHIT_LOCALX_LEN-1:0] hit_localx,
    input  logic [HEG2SFHIT_LOCALY_LEN-1:0] hit_localy,
    input  logic [W_R-1:0]                  hit_r_offset,
    input  logic                            acc_rdy,
    output logic                            dp_hit_vld,
    output logic [HEG2SFHIT_LOCALX_LEN-1:0] dp_localx,
    output logic [HEG2SFHIT_LOCALY_LEN-1:0] dp_localy,
    output logic [W_R-1:0]                  dp_r_offset,
    output logic [W_TH-1:0]                 theta_addr,
    output logic                            tag_vld,
    output logic [W_TH-1:0]                 tag_theta,
    output logic                            scan_done,
    output logic                            busy
);

    localparam int unsigned HitW = HEG2SFHIT_LOCALX_LEN + HEG2SFHIT_LOCALY_LEN + W_R;
    localparam int unsigned DrnW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [W_TH-1:0] ThetaLast = W_TH'(THETA_BINS - 1);
    localparam logic [DrnW-1:0] DrainLast = DrnW'(PIPE_LAT - 1);

    if (PIPE_LAT < 1) begin : g_chk_lat
        $error("PIPE_LAT must be at least 1");
    end
    if (THETA_BINS < 1 || THETA_BINS > (32'd1 << W_TH)) begin : g_chk_theta
        $error("THETA_BINS must fit in W_TH address bits");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("FIFO_DEPTH must be a power of two, at least 2");
    end

    typedef enum logic [1:0] {StIdle, StScan, StDrain} state_e;

    state_e            state_q, state_d;
    logic [W_TH-1:0]   theta_q, theta_d;
    logic [DrnW-1:0]   drain_q, drain_d;
    logic              rdy_en_q;
    logic [HitW-1:0]   op_q;
    logic [HitW-1:0]   hit_word;
    logic [HitW-1:0]   head_word;
    logic              buf_empty;
    logic              push;
    logic              pop;

    assign hit_word = {hit_localx, hit_localy, hit_r_offset};
    assign push     = hit_vld && hit_rdy;

    // Holds hit_rdy low until the first clock edge after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
        end
    end

`ifdef LSF_HIT_FIFO_EN
    localparam int unsigned AddrW = $clog2(FIFO_DEPTH);

    logic [HitW-1:0]  mem_q [FIFO_DEPTH];
    logic [AddrW-1:0] wr_ptr_q;
    logic [AddrW-1:0] rd_ptr_q;
    logic [AddrW:0]   count_q;
    logic             buf_full;

    assign buf_empty = (count_q == '0);
    assign buf_full  = (count_q == (AddrW + 1)'(FIFO_DEPTH));
    // Ready depends only on stored occupancy, never on a same-cycle pop.
    assign hit_rdy   = rdy_en_q && !buf_full;
    assign head_word = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= hit_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AddrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AddrW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (AddrW + 1)'(1);
                2'b01:   count_q <= count_q - (AddrW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end
`else
    logic            buf_vld_q;
    logic [HitW-1:0] buf_q;

    assign buf_empty = !buf_vld_q;
    assign hit_rdy   = rdy_en_q && (state_q == StIdle) && !buf_vld_q;
    assign head_word = buf_q;

    always_ff @(posedge clk) begin
        if (push) begin
            buf_q <= hit_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_vld_q <= 1'b0;
        end else if (push) begin
            buf_vld_q <= 1'b1;
        end else if (pop) begin
            buf_vld_q <= 1'b0;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        theta_d    = theta_q;
        drain_d    = drain_q;
        pop        = 1'b0;
        dp_hit_vld = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!buf_empty) begin
                    pop     = 1'b1;
                    theta_d = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (acc_rdy) begin
                    dp_hit_vld = 1'b1;
                    if (theta_q == ThetaLast) begin
                        theta_d = '0;
                        if (!buf_empty) begin
                            pop = 1'b1;
                        end else begin
                            drain_d = '0;
                            state_d = StDrain;
                        end
                    end else begin
                        theta_d = theta_q + W_TH'(1);
                    end
                end
            end
            StDrain: begin
                if (drain_q == DrainLast) begin
                    state_d = StIdle;
                end else begin
                    drain_d = drain_q + DrnW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            theta_q <= '0;
            drain_q <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            theta_q <= theta_d;
            drain_q <= drain_d;
            if (pop) begin
                op_q <= head_word;
            end
        end
    end

    // Tag pipeline mirrors the r-bin datapath latency and never stalls.
    logic [PIPE_LAT-1:0]            tag_vld_q;
    logic [PIPE_LAT-1:0][W_TH-1:0]  tag_th_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld_q <= '0;
            tag_th_q  <= '0;
        end else begin
            tag_vld_q[0] <= dp_hit_vld;
            tag_th_q[0]  <= theta_q;
            for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_th_q[i]  <= tag_th_q[i-1];
            end
        end
    end

    assign {dp_localx, dp_localy, dp_r_offset} = op_q;
    assign theta_addr = theta_q;
    assign scan_done  = dp_hit_vld && (theta_q == ThetaLast);
    assign busy       = (state_q != StIdle) || !buf_empty;
    assign tag_vld    = tag_vld_q[PIPE_LAT-1];
    assign tag_theta  = tag_th_q[PIPE_LAT-1];

endmodule

// File: tb/tb_lsf_theta_scan_ctrl.sv
// Directed bench for lsf_theta_scan_ctrl; FIFO-only scenarios are built when LSF_HIT_FIFO_EN is set.
`timescale 1ns/1ps
module tb_lsf_theta_scan_ctrl;

    localparam int unsigned THETA_BINS = 128;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned PIPE_LAT   = 2;
    localparam int unsigned W_R        = 22;
    localparam int unsigned W_TH       = 7;
    localparam int unsigned W_X        = 16;
    localparam int unsigned W_Y        = 16;
    localparam int          MAX_OBS    = 1400;

    typedef struct packed {
        logic [W_X-1:0] x;
        logic [W_Y-1:0] y;
        logic [W_R-1:0] off;
    } hit_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            hit_vld;
    logic            hit_rdy;
    logic [W_X-1:0]  hit_localx;
    logic [W_Y-1:0]  hit_localy;
    logic [W_R-1:0]  hit_r_offset;
    logic            acc_rdy;
    logic            dp_hit_vld;
    logic [W_X-1:0]  dp_localx;
    logic [W_Y-1:0]  dp_localy;
    logic [W_R-1:0]  dp_r_offset;
    logic [W_TH-1:0] theta_addr;
    logic            tag_vld;
    logic [W_TH-1:0] tag_theta;
    logic            scan_done;
    logic            busy;

    int checks = 0;
    int errors = 0;

    hit_t push_q[$];
    hit_t exp_hits[$];

    logic            o_vld [MAX_OBS];
    logic [W_TH-1:0] o_th  [MAX_OBS];
    logic            o_sd  [MAX_OBS];
    logic            o_tv  [MAX_OBS];
    logic [W_TH-1:0] o_tt  [MAX_OBS];
    logic            o_bsy [MAX_OBS];
    logic            o_rdy [MAX_OBS];
    logic            o_acc [MAX_OBS];
    logic [W_X-1:0]  o_x   [MAX_OBS];
    logic [W_Y-1:0]  o_y   [MAX_OBS];
    logic [W_R-1:0]  o_off [MAX_OBS];

    int a_n, a_first, a_last, a_th_bad, a_op_bad, a_sd_n, a_sd_bad, a_tag_n, a_tag_bad;
    int a_cyc [MAX_OBS];

    always #5 clk = ~clk;

    lsf_theta_scan_ctrl #(
        .THETA_BINS           (THETA_BINS),
        .FIFO_DEPTH           (FIFO_DEPTH),
        .PIPE_LAT             (PIPE_LAT),
        .W_R                  (W_R),
        .W_TH                 (W_TH),
        .HEG2SFHIT_LOCALX_LEN (W_X),
        .HEG2SFHIT_LOCALY_LEN (W_Y)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hit_vld      (hit_vld),
        .hit_rdy      (hit_rdy),
        .hit_localx   (hit_localx),
        .hit_localy   (hit_localy),
        .hit_r_offset (hit_r_offset),
        .acc_rdy      (acc_rdy),
        .dp_hit_vld   (dp_hit_vld),
        .dp_localx    (dp_localx),
        .dp_localy    (dp_localy),
        .dp_r_offset  (dp_r_offset),
        .theta_addr   (theta_addr),
        .tag_vld      (tag_vld),
        .tag_theta    (tag_theta),
        .scan_done    (scan_done),
        .busy         (busy)
    );

    function automatic hit_t mk_hit(input int unsigned x, input int unsigned y,
                                    input int unsigned off);
        hit_t h;
        h.x   = W_X'(x);
        h.y   = W_Y'(y);
        h.off = W_R'(off);
        return h;
    endfunction

    // Runs a fixed number of cycles from posedge+1: offers push_q, optionally holds acc_rdy low
    // for the first 'hold' cycles and stalls stall_len cycles when theta_addr reaches stall_th.
    task automatic observe(input int cycles, input int stall_th, input int stall_len,
                           input int hold);
        int  left;
        bit  fired;
        left  = 0;
        fired = 1'b0;
        for (int c = 0; c < cycles && c < MAX_OBS; c++) begin
            if (push_q.size() > 0) begin
                hit_vld      = 1'b1;
                hit_localx   = push_q[0].x;
                hit_localy   = push_q[0].y;
                hit_r_offset = push_q[0].off;
            end else begin
                hit_vld = 1'b0;
            end
            if (!fired && stall_len > 0 && busy && theta_addr == W_TH'(stall_th)) begin
                fired = 1'b1;
                left  = stall_len;
            end
            acc_rdy = !((c < hold) || (left > 0));
            if (left > 0) left--;
            @(negedge clk);
            o_vld[c] = dp_hit_vld;
            o_th[c]  = theta_addr;
            o_sd[c]  = scan_done;
            o_tv[c]  = tag_vld;
            o_tt[c]  = tag_theta;
            o_bsy[c] = busy;
            o_rdy[c] = hit_rdy;
            o_acc[c] = hit_vld && hit_rdy;
            o_x[c]   = dp_localx;
            o_y[c]   = dp_localy;
            o_off[c] = dp_r_offset;
            if (hit_vld && hit_rdy) void'(push_q.pop_front());
            @(posedge clk);
            #1;
        end
        hit_vld = 1'b0;
        acc_rdy = 1'b1;
    endtask

    // Reduces a recorded window against exp_hits: issue k must carry theta k mod THETA_BINS
    // and operands of hit k/THETA_BINS; scan_done on every THETA_BINS-th issue; tags PIPE_LAT later.
    task automatic analyze(input int cycles);
        a_n = 0; a_first = -1; a_last = -1; a_th_bad = 0; a_op_bad = 0;
        a_sd_n = 0; a_sd_bad = 0; a_tag_n = 0; a_tag_bad = 0;
        for (int c = 0; c < cycles; c++) begin
            logic exp_sd;
            exp_sd = 1'b0;
            if (o_vld[c] === 1'b1) begin
                if (a_first < 0) a_first = c;
                a_last     = c;
                a_cyc[a_n] = c;
                if (o_th[c] !== W_TH'(a_n % THETA_BINS)) a_th_bad++;
                if (a_n / THETA_BINS >= exp_hits.size()) a_op_bad++;
                else if ({o_x[c], o_y[c], o_off[c]} !== exp_hits[a_n / THETA_BINS]) a_op_bad++;
                exp_sd = (((a_n + 1) % THETA_BINS) == 0);
                if (c + PIPE_LAT < cycles &&
                    (o_tv[c+PIPE_LAT] !== 1'b1 || o_tt[c+PIPE_LAT] !== o_th[c])) a_tag_bad++;
                a_n++;
            end
            if (o_sd[c] !== exp_sd) a_sd_bad++;
            if (o_sd[c] === 1'b1) a_sd_n++;
            if (o_tv[c] === 1'b1) a_tag_n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; hit_vld = 1'b0; acc_rdy = 1'b1;
        hit_localx = '0; hit_localy = '0; hit_r_offset = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (dp_hit_vld !== 1'b0) begin errors++; $display("FAIL reset_dp_vld: got %b expected 0", dp_hit_vld); end
        checks++; if (theta_addr !== '0) begin errors++; $display("FAIL reset_theta: got %0d expected 0", theta_addr); end
        checks++; if (scan_done !== 1'b0) begin errors++; $display("FAIL reset_scan_done: got %b expected 0", scan_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (hit_rdy !== 1'b0) begin errors++; $display("FAIL reset_hit_rdy: got %b expected 0", hit_rdy); end
        checks++; if (tag_vld !== 1'b0 || tag_theta !== '0) begin errors++; $display("FAIL reset_tag: got vld=%b th=%0d expected 0/0", tag_vld, tag_theta); end
        rst = 1'b0;
        #1;
        checks++; if (hit_rdy !== 1'b0) begin errors++; $display("FAIL rdy_before_edge: got %b expected 0", hit_rdy); end
        @(posedge clk);
        #1;
        checks++; if (hit_rdy !== 1'b1) begin errors++; $display("FAIL rdy_after_edge: got %b expected 1", hit_rdy); end
    endtask

    task automatic test_single_hit();
        push_q.delete(); exp_hits.delete();
        push_q.push_back(mk_hit(100, 16'hFFCE, 3));   // y = -50
        exp_hits.push_back(mk_hit(100, 16'hFFCE, 3));
        observe(150, -1, 0, 0);
        analyze(150);
        // accepted cycle 0, popped from IDLE in cycle 1, first issue in cycle 2
        checks++; if (a_first !== 2) begin errors++; $display("FAIL single_first_issue: got %0d expected 2", a_first); end
        checks++; if (a_n !== 128) begin errors++; $display("FAIL single_issue_count: got %0d expected 128", a_n); end
        checks++; if (a_last - a_first + 1 !== 128) begin errors++; $display("FAIL single_contiguous: got span %0d expected 128", a_last - a_first + 1); end
        checks++; if (a_th_bad !== 0) begin errors++; $display("FAIL single_theta_seq: got %0d bad expected 0", a_th_bad); end
        checks++; if (a_op_bad !== 0) begin errors++; $display("FAIL single_operands: got %0d bad expected 0", a_op_bad); end
        checks++; if (a_sd_n !== 1 || a_sd_bad !== 0) begin errors++; $display("FAIL single_scan_done: got n=%0d bad=%0d expected 1/0", a_sd_n, a_sd_bad); end
        checks++; if (a_tag_n !== 128 || a_tag_bad !== 0) begin errors++; $display("FAIL single_tags: got n=%0d bad=%0d expected 128/0", a_tag_n, a_tag_bad); end
        checks++; if (o_bsy[a_last+2] !== 1'b1 || o_bsy[a_last+3] !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b%b expected 10", o_bsy[a_last+2], o_bsy[a_last+3]); end
    endtask

    task automatic test_stall();
        int held;
        push_q.delete(); exp_hits.delete();
        push_q.push_back(mk_hit(7, 9, 11));
        exp_hits.push_back(mk_hit(7, 9, 11));
        observe(170, 40, 5, 0);
        analyze(170);
        held = 0;
        for (int c = a_cyc[39] + 1; c < a_cyc[40] && c < MAX_OBS; c++)
            if (o_vld[c] === 1'b0 && o_th[c] === W_TH'(40)) held++;
        checks++; if (a_n !== 128) begin errors++; $display("FAIL stall_issue_count: got %0d expected 128", a_n); end
        checks++; if (a_th_bad !== 0) begin errors++; $display("FAIL stall_theta_seq: got %0d bad expected 0", a_th_bad); end
        checks++; if (a_cyc[40] - a_cyc[39] !== 6) begin errors++; $display("FAIL stall_gap: got %0d expected 6", a_cyc[40] - a_cyc[39]); end
        checks++; if (held !== 5) begin errors++; $display("FAIL stall_hold_theta40: got %0d expected 5", held); end
        checks++; if (a_op_bad !== 0 || a_sd_bad !== 0) begin errors++; $display("FAIL stall_ops_sd: got %0d/%0d expected 0/0", a_op_bad, a_sd_bad); end
        checks++; if (a_tag_n !== 128 || a_tag_bad !== 0) begin errors++; $display("FAIL stall_tags: got n=%0d bad=%0d expected 128/0", a_tag_n, a_tag_bad); end
    endtask

`ifdef LSF_HIT_FIFO_EN
    task automatic test_back_to_back();
        int sd_bad;
        push_q.delete(); exp_hits.delete();
        for (int i = 1; i <= 3; i++) begin
            push_q.push_back(mk_hit(i * 10, i * 20, i));
            exp_hits.push_back(mk_hit(i * 10, i * 20, i));
        end
        observe(420, -1, 0, 0);
        analyze(420);
        sd_bad = 0;
        if (o_sd[a_cyc[127]] !== 1'b1) sd_bad++;
        if (o_sd[a_cyc[255]] !== 1'b1) sd_bad++;
        if (o_sd[a_cyc[383]] !== 1'b1) sd_bad++;
        checks++; if (a_n !== 384) begin errors++; $display("FAIL b2b_issue_count: got %0d expected 384", a_n); end
        checks++; if (a_last - a_first + 1 !== 384) begin errors++; $display("FAIL b2b_no_gap: got span %0d expected 384", a_last - a_first + 1); end
        checks++; if (a_sd_n !== 3 || sd_bad !== 0 || a_sd_bad !== 0) begin errors++; $display("FAIL b2b_scan_done: got n=%0d bad=%0d expected 3/0", a_sd_n, sd_bad + a_sd_bad); end
        checks++; if (a_op_bad !== 0 || a_th_bad !== 0) begin errors++; $display("FAIL b2b_order: got %0d/%0d bad expected 0/0", a_op_bad, a_th_bad); end
    endtask

    task automatic test_fifo_full();
        int acc_hold, first_low;
        push_q.delete(); exp_hits.delete();
        for (int i = 1; i <= 10; i++) begin
            push_q.push_back(mk_hit(i * 3 + 1, 1000 + i, i * 7));
            exp_hits.push_back(mk_hit(i * 3 + 1, 1000 + i, i * 7));
        end
        observe(1320, -1, 0, 20);
        analyze(1320);
        acc_hold = 0; first_low = -1;
        for (int c = 0; c < 20; c++) begin
            if (o_acc[c] === 1'b1) acc_hold++;
            if (first_low < 0 && o_rdy[c] === 1'b0) first_low = c;
        end
        // first hit is moved into the operand registers, then 8 more fill the buffer
        checks++; if (acc_hold !== 9) begin errors++; $display("FAIL full_accepted: got %0d expected 9", acc_hold); end
        checks++; if (first_low !== 9) begin errors++; $display("FAIL full_rdy_drop: got cycle %0d expected 9", first_low); end
        checks++; if (o_rdy[a_cyc[127]] !== 1'b0 || o_rdy[a_cyc[127]+1] !== 1'b1) begin errors++; $display("FAIL full_pop_no_bypass: got %b%b expected 01", o_rdy[a_cyc[127]], o_rdy[a_cyc[127]+1]); end
        checks++; if (a_n !== 1280 || a_op_bad !== 0 || a_th_bad !== 0) begin errors++; $display("FAIL full_order: got n=%0d bad=%0d expected 1280/0", a_n, a_op_bad + a_th_bad); end
    endtask
`else
    task automatic test_single_entry_b2b();
        int rdy_hi;
        push_q.delete(); exp_hits.delete();
        push_q.push_back(mk_hit(5, 6, 7));
        push_q.push_back(mk_hit(8, 9, 10));
        exp_hits.push_back(mk_hit(5, 6, 7));
        exp_hits.push_back(mk_hit(8, 9, 10));
        observe(290, -1, 0, 0);
        analyze(290);
        rdy_hi = 0;
        for (int c = 1; c <= a_cyc[127] + int'(PIPE_LAT) && c < MAX_OBS; c++)
            if (o_rdy[c] === 1'b1) rdy_hi++;
        checks++; if (rdy_hi !== 0) begin errors++; $display("FAIL single_rdy_mid_scan: got %0d high cycles expected 0", rdy_hi); end
        checks++; if (o_rdy[a_cyc[127] + PIPE_LAT + 1] !== 1'b1) begin errors++; $display("FAIL single_rdy_idle: got %b expected 1", o_rdy[a_cyc[127] + PIPE_LAT + 1]); end
        checks++; if (a_cyc[128] - a_cyc[127] < int'(PIPE_LAT) + 1) begin errors++; $display("FAIL single_b2b_bubble: got %0d expected >= %0d", a_cyc[128] - a_cyc[127], PIPE_LAT + 1); end
        checks++; if (a_n !== 256 || a_op_bad !== 0 || a_sd_n !== 2) begin errors++; $display("FAIL single_b2b_issues: got n=%0d bad=%0d sd=%0d expected 256/0/2", a_n, a_op_bad, a_sd_n); end
    endtask
`endif

    task automatic test_reset_midscan();
        push_q.delete(); exp_hits.delete();
        push_q.push_back(mk_hit(111, 222, 333));
        push_q.push_back(mk_hit(444, 555, 666));
        observe(62, -1, 0, 0);
        checks++; if (theta_addr !== W_TH'(60) || dp_hit_vld !== 1'b1) begin errors++; $display("FAIL rst_mid_setup: got th=%0d vld=%b expected 60/1", theta_addr, dp_hit_vld); end
        #1 rst = 1'b1;
        #1;
        checks++; if (dp_hit_vld !== 1'b0 || tag_vld !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_async: got vld=%b tag=%b busy=%b expected 000", dp_hit_vld, tag_vld, busy); end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        push_q.delete();
        push_q.push_back(mk_hit(777, 888, 999));
        exp_hits.push_back(mk_hit(777, 888, 999));
        observe(150, -1, 0, 0);
        analyze(150);
        checks++; if (a_n !== 128 || a_th_bad !== 0) begin errors++; $display("FAIL rst_mid_rescan: got n=%0d thbad=%0d expected 128/0", a_n, a_th_bad); end
        checks++; if (a_op_bad !== 0) begin errors++; $display("FAIL rst_mid_discard: got %0d bad expected 0", a_op_bad); end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_stall();
`ifdef LSF_HIT_FIFO_EN
        test_back_to_back();
        test_fifo_full();
`else
        test_single_entry_b2b();
`endif
        test_reset_midscan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsf_theta_scan_ctrl.md
LSF_THETA_SCAN_CTRL -- requirements
Module: lsf_theta_scan_ctrl

Interface
REQ-001 Parameters (name, default, meaning):
- THETA_BINS, 128: theta steps per hit.
- FIFO_DEPTH, 8: hit buffer entries, power of 2.
- PIPE_LAT, 2: r-bin datapath latency in cycles.
- W_R, 22: r-offset width.
- W_TH, 7: theta address width; THETA_BINS ≤ 2^W_TH.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: clock.
- rst, in, 1: asynchronous active-high reset.
- hit_vld, in, 1: input hit valid.
- hit_rdy, out, 1: hit accepted when hit_vld and hit_rdy are both 1.
- hit_localx, in, HEG2SFHIT_LOCALX_LEN: hit x.
- hit_localy, in, HEG2SFHIT_LOCALY_LEN: hit y.
- hit_r_offset, in, W_R: drift-radius offset.
- acc_rdy, in, 1: accumulator can take a result; 0 stalls the scan.
- dp_hit_vld, out, 1: datapath issue strobe.
- dp_localx, dp_localy, dp_r_offset, out, as the matching inputs: operands for the issue.
- theta_addr, out, W_TH: sin/cos LUT address for the issue.
- tag_vld, out, 1: dp_hit_vld delayed by PIPE_LAT.
- tag_theta, out, W_TH: theta_addr delayed by PIPE_LAT; aligns with r_bin.
- scan_done, out, 1: one-cycle pulse when the last theta of a hit issues.
- busy, out, 1: high whenever state ≠ IDLE or the buffer is non-empty.

Function
REQ-003 The FSM SHALL have states IDLE, SCAN and DRAIN.
REQ-004 IDLE → SCAN when the buffer is non-empty. The head hit is popped into the operand registers in that same cycle, and theta_cnt is set to 0.
REQ-005 In SCAN with acc_rdy=1:
- the block SHALL assert dp_hit_vld=1 with theta_addr=theta_cnt, then increment theta_cnt;
- the operand registers SHALL hold constant for the whole scan of a hit.
REQ-006 In SCAN with acc_rdy=0, the block SHALL drive dp_hit_vld=0 and hold theta_cnt, operands and state.
REQ-007 Issue at theta_cnt=THETA_BINS-1 SHALL pulse scan_done, with these next-state rules:
- buffer non-empty: pop the next hit, reset theta_cnt to 0, stay in SCAN (zero-bubble back-to-back);
- buffer empty: go to DRAIN.
REQ-008 DRAIN SHALL last exactly PIPE_LAT cycles with dp_hit_vld=0, then go to IDLE. A hit arriving during DRAIN is buffered and taken from IDLE.
REQ-009 tag_vld/tag_theta SHALL be a PIPE_LAT-stage shift of dp_hit_vld/theta_addr that advances every cycle, independent of acc_rdy.
REQ-010 Buffer full: hit_rdy=0.
REQ-011 Simultaneous push and pop on a full buffer:
- hit_rdy SHALL remain 0 (no combinational ready-from-pop);
- push and pop in the same cycle are otherwise legal, and occupancy is unchanged.
REQ-012 Buffer order SHALL be FIFO. Pointers SHALL wrap modulo FIFO_DEPTH, with occupancy tracked in a separate counter of width log2(FIFO_DEPTH)+1.
REQ-013 theta_cnt SHALL never exceed THETA_BINS-1.
REQ-014 Total issues per accepted hit SHALL equal exactly THETA_BINS, regardless of stall pattern.

Reset
REQ-015 While rst=1, the block SHALL clear asynchronously:
- state=IDLE, theta_cnt=0, buffer empty;
- all tag stages=0;
- dp_hit_vld=0, theta_addr=0, scan_done=0, busy=0, hit_rdy=0.
REQ-016 hit_rdy SHALL become 1 the first clock edge after rst deasserts.
REQ-017 Reset mid-scan SHALL discard the current hit and all buffered hits with no further issues. In-flight tags SHALL be cleared.

Configuration
REQ-018 With macro LSF_HIT_FIFO_EN defined, the block SHALL use a FIFO_DEPTH-entry buffer as specified above.
REQ-019 Without LSF_HIT_FIFO_EN:
- the buffer is a single register, and hit_rdy=1 only in IDLE with that register empty;
- back-to-back hits SHALL incur the DRAIN and IDLE cycles;
- all other behaviour is unchanged.

Verification
REQ-020 Single hit, acc_rdy=1 throughout (x=100, y=-50, off=3):
- 128 consecutive dp_hit_vld cycles, theta_addr 0..127, operands constant;
- scan_done on the theta=127 cycle;
- tag_theta 0..127 lags by 2 cycles;
- busy falls 2 cycles after scan_done plus the IDLE transition.
REQ-021 Three hits pushed back-to-back (FIFO enabled): 384 contiguous issues with no gap; 3 scan_done pulses at issue counts 128, 256 and 384.
REQ-022 acc_rdy driven low for 5 cycles at theta=40: issues pause, theta resumes at 40, total issues still 128, no duplicates.
REQ-023 Push 9 hits with no pops (acc_rdy=0, FIFO_DEPTH=8):
- hit_rdy drops after the pop-free fill reaches full;
- no hit is lost, and output order matches input order.
REQ-024 Assert rst at theta=60: dp_hit_vld, tag_vld and busy go to 0 immediately; after release, a new hit scans from theta=0.
REQ-025 Macro undefined: a second hit offered mid-scan sees hit_rdy=0 until IDLE; its first issue is ≥ PIPE_LAT+1 cycles after the first hit's scan_done.
